// File: rtl/rope_node_chain.sv
// N-node rope segment: Q16.16 node positions updated by a one-hot token ring
// that alternates a neighbour-constraint phase and a mouse phase per node.
module rope_node_chain #(
  parameter int          NODE_CONTAINS = 5,
  parameter int          CORE_ID       = 1,
  parameter logic [31:0] SPACING       = 32'h0008_0000,
  parameter logic [31:0] MAX_SEG       = 32'h0008_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                prev_core_last_x,
  input  logic [31:0]                prev_core_last_y,
  input  logic [31:0]                next_core_first_x,
  input  logic [31:0]                next_core_first_y,
  input  logic [31:0]                x_mouse,
  input  logic [31:0]                y_mouse,
  input  logic                       is_last,
  output logic [32*NODE_CONTAINS-1:0] nodes_x,
  output logic [32*NODE_CONTAINS-1:0] nodes_y
);

  localparam int N = NODE_CONTAINS;
  localparam logic signed [33:0] MAX_D = $signed({2'b00, MAX_SEG});

  // One axis of the constraint: relax toward neighbours, then clamp the
  // offset from the predecessor. 34 bits keep the sums and the difference exact.
  function automatic logic [31:0] constrain(input logic [31:0] p, input logic [31:0] c,
                                            input logic [31:0] nx, input logic last);
    logic signed [33:0] ps, cs, ns, m, cand, d, sum;
    ps = $signed({{2{p[31]}}, p});
    cs = $signed({{2{c[31]}}, c});
    ns = $signed({{2{nx[31]}}, nx});
    m  = '0;
    if (last) begin
      cand = cs;
    end else begin
      m    = (ps + ns) >>> 1;
      cand = (m + cs) >>> 1;
    end
    d = cand - ps;
    if (d > MAX_D)       d = MAX_D;
    else if (d < -MAX_D) d = -MAX_D;
    sum = ps + d;
    return sum[31:0];
  endfunction

  logic [2*N-1:0] tok;
  logic [31:0]    x_q   [N];
  logic [31:0]    y_q   [N];
  logic [31:0]    new_x [N];
  logic [31:0]    new_y [N];

  // Boundary inputs that a head segment never consults, and mouse inputs
  // that a non-head segment never consults.
  logic unused_inputs;
  assign unused_inputs = ^{prev_core_last_x, prev_core_last_y, x_mouse, y_mouse};

  always_ff @(posedge clk) begin
    if (reset) tok <= {{(2*N-1){1'b0}}, 1'b1};
    else       tok <= {tok[2*N-2:0], tok[2*N-1]};
  end

  for (genvar i = 0; i < N; i++) begin : g_node
    localparam int unsigned G     = (CORE_ID - 1) * N + i + 1;
    localparam logic [31:0] RST_X = G * SPACING;
    localparam bit          HEAD  = (CORE_ID == 1) && (i == 0);

    logic [31:0] xr, yr;

    if (HEAD) begin : g_head
      assign new_x[i] = xr;
      assign new_y[i] = yr;
    end else begin : g_pull
      logic [31:0] p_x, p_y, n_x, n_y;
      logic        last;
      if (i == 0) begin : g_p_ext
        assign p_x = prev_core_last_x;
        assign p_y = prev_core_last_y;
      end else begin : g_p_int
        assign p_x = x_q[i-1];
        assign p_y = y_q[i-1];
      end
      if (i == N - 1) begin : g_n_ext
        assign n_x  = next_core_first_x;
        assign n_y  = next_core_first_y;
        assign last = is_last;
      end else begin : g_n_int
        assign n_x  = x_q[i+1];
        assign n_y  = y_q[i+1];
        assign last = 1'b0;
      end
      assign new_x[i] = constrain(p_x, xr, n_x, last);
      assign new_y[i] = constrain(p_y, yr, n_y, last);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        xr <= RST_X;
        yr <= '0;
      end else if (tok[i]) begin
        xr <= new_x[i];
        yr <= new_y[i];
      end else if (tok[i+N] && HEAD) begin
        xr <= x_mouse;
        yr <= y_mouse;
      end
    end

    assign x_q[i]             = xr;
    assign y_q[i]             = yr;
    assign nodes_x[32*i +: 32] = xr;
    assign nodes_y[32*i +: 32] = yr;
  end

endmodule

// File: tb/tb_rope_node_chain.sv
// Bench for rope_node_chain: directed vector table on a head segment, random
// scoreboard run against a behavioural model, plus last-node and sign checks.
module tb_rope_node_chain;
  localparam int N  = 5;
  localparam int W  = 32 * N;
  localparam int NC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: head segment (CORE_ID=1, N=5)
  logic         rst_a = 1'b1;
  logic [31:0]  prev_x_a = '0, prev_y_a = '0;
  logic [31:0]  next_x_a = 32'h0030_0000, next_y_a = '0;
  logic [31:0]  mx_a = '0, my_a = '0;
  logic         last_a = 1'b0;
  logic [W-1:0] nodes_x_a, nodes_y_a;

  // Instance B: second segment, last in chain
  logic         rst_b = 1'b1;
  logic [31:0]  mx_b = 32'h4000_0000, my_b = 32'h4000_0000;
  logic [W-1:0] nodes_x_b, nodes_y_b;

  // Instance C: two-node head segment with zero spacing
  logic          rst_c = 1'b1;
  logic [31:0]   mx_c = 32'hFFF8_0000, my_c = '0;
  logic [32*NC-1:0] nodes_x_c, nodes_y_c;

  rope_node_chain #(.NODE_CONTAINS(N), .CORE_ID(1)) dut_a (
    .clk(clk), .reset(rst_a),
    .prev_core_last_x(prev_x_a), .prev_core_last_y(prev_y_a),
    .next_core_first_x(next_x_a), .next_core_first_y(next_y_a),
    .x_mouse(mx_a), .y_mouse(my_a), .is_last(last_a),
    .nodes_x(nodes_x_a), .nodes_y(nodes_y_a));

  rope_node_chain #(.NODE_CONTAINS(N), .CORE_ID(2)) dut_b (
    .clk(clk), .reset(rst_b),
    .prev_core_last_x(32'h0), .prev_core_last_y(32'h0),
    .next_core_first_x(32'h7FFF_0000), .next_core_first_y(32'h7FFF_0000),
    .x_mouse(mx_b), .y_mouse(my_b), .is_last(1'b1),
    .nodes_x(nodes_x_b), .nodes_y(nodes_y_b));

  rope_node_chain #(.NODE_CONTAINS(NC), .CORE_ID(1), .SPACING(32'h0)) dut_c (
    .clk(clk), .reset(rst_c),
    .prev_core_last_x(32'h1234_0000), .prev_core_last_y(32'h5678_0000),
    .next_core_first_x(32'h0), .next_core_first_y(32'h0),
    .x_mouse(mx_c), .y_mouse(my_c), .is_last(1'b0),
    .nodes_x(nodes_x_c), .nodes_y(nodes_y_c));

  typedef struct {
    bit          rst;
    logic [31:0] mx, my;
    int          node;
    logic [31:0] ex, ey;
    bit          full;
  } vec_t;

  vec_t vecs[$];
  logic [2*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl_x [N];
  logic [31:0] mdl_y [N];
  int          mdl_tok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit rst, input logic [31:0] mx, input logic [31:0] my,
                         input int node, input logic [31:0] ex, input logic [31:0] ey,
                         input bit full);
    vec_t v;
    v.rst = rst; v.mx = mx; v.my = my; v.node = node; v.ex = ex; v.ey = ey; v.full = full;
    vecs.push_back(v);
  endtask

  // Rest-configuration checks for edges 0..4 after a reset release.
  task automatic add_rest(input logic [31:0] mx, input logic [31:0] my);
    for (int k = 0; k < N; k++)
      add_vec(1'b0, mx, my, k, 32'(k + 1) * 32'h0008_0000, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] m_axis(input logic [31:0] p, input logic [31:0] c,
                                         input logic [31:0] n, input bit last);
    longint lp, lc, ln, cand, d, r;
    lp = longint'($signed(p));
    lc = longint'($signed(c));
    ln = longint'($signed(n));
    if (last) cand = lc;
    else      cand = (((lp + ln) >>> 1) + lc) >>> 1;
    d = cand - lp;
    if (d > 64'sd524288)  d = 64'sd524288;
    if (d < -64'sd524288) d = -64'sd524288;
    r = lp + d;
    return r[31:0];
  endfunction

  task automatic model_step(input bit rst, input logic [31:0] mx, input logic [31:0] my,
                            input logic [31:0] nx, input logic [31:0] ny, input bit lst);
    int k;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mdl_x[i] = 32'(i + 1) * 32'h0008_0000;
        mdl_y[i] = '0;
      end
      mdl_tok = 0;
      return;
    end
    k = mdl_tok;
    if (k > 0 && k < N) begin
      mdl_x[k] = m_axis(mdl_x[k-1], mdl_x[k], (k == N-1) ? nx : mdl_x[k+1], lst && k == N-1);
      mdl_y[k] = m_axis(mdl_y[k-1], mdl_y[k], (k == N-1) ? ny : mdl_y[k+1], lst && k == N-1);
    end else if (k == N) begin
      mdl_x[0] = mx;
      mdl_y[0] = my;
    end
    mdl_tok = (mdl_tok + 1) % (2 * N);
  endtask

  function automatic logic [31:0] rnd_coord();
    logic [31:0] v;
    if ($urandom_range(0, 9) == 0) v = $urandom();
    else v = 32'($urandom_range(0, 32'h0100_0000)) - 32'h0080_0000;
    return v;
  endfunction

  initial begin
    logic [2*W-1:0] e, got;
    bit r;

    // Rest configuration, mouse load at edge 5, token period of 10
    add_vec(1'b1, 32'h0003_0000, 32'h0004_0000, 0, 32'h0008_0000, 32'h0, 1'b1);
    add_rest(32'h0003_0000, 32'h0004_0000);
    add_vec(1'b0, 32'h0003_0000, 32'h0004_0000, 0, 32'h0003_0000, 32'h0004_0000, 1'b0);
    for (int k = 6; k <= 14; k++)
      add_vec(1'b0, 32'h0050_0000, 32'h0050_0000, 0, 32'h0003_0000, 32'h0004_0000, 1'b0);
    add_vec(1'b0, 32'h0050_0000, 32'h0050_0000, 0, 32'h0050_0000, 32'h0050_0000, 1'b0);

    // Pull test: node1 and node2 clamp to +/-8.0 from their predecessors
    add_vec(1'b1, 32'h0, 32'h0020_0000, 4, 32'h0028_0000, 32'h0, 1'b0);
    add_rest(32'h0, 32'h0020_0000);
    add_vec(1'b0, 32'h0, 32'h0020_0000, 0, 32'h0, 32'h0020_0000, 1'b0);
    for (int k = 6; k <= 10; k++)
      add_vec(1'b0, 32'h0, 32'h0020_0000, 1, 32'h0010_0000, 32'h0, 1'b0);
    add_vec(1'b0, 32'h0, 32'h0020_0000, 1, 32'h0008_0000, 32'h0018_0000, 1'b0);
    add_vec(1'b0, 32'h0, 32'h0020_0000, 2, 32'h0010_0000, 32'h0010_0000, 1'b0);

    // Reset asserted while the token sits on bit 7
    add_vec(1'b1, 32'h0001_0000, 32'h0001_0000, 0, 32'h0008_0000, 32'h0, 1'b0);
    add_rest(32'h0001_0000, 32'h0001_0000);
    add_vec(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    add_vec(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    add_vec(1'b1, 32'h0001_0000, 32'h0001_0000, 0, 32'h0008_0000, 32'h0, 1'b1);
    for (int k = 0; k < N; k++)
      add_vec(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0008_0000, 32'h0, 1'b0);
    add_vec(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0001_0000, 32'h0001_0000, 1'b0);

    foreach (vecs[j]) begin
      rst_a = vecs[j].rst;
      mx_a  = vecs[j].mx;
      my_a  = vecs[j].my;
      tick();
      if (vecs[j].full) begin
        for (int k = 0; k < N; k++) begin
          chk($sformatf("vec%0d_rst_x%0d", j, k), nodes_x_a[32*k +: 32], 32'(k + 1) * 32'h0008_0000);
          chk($sformatf("vec%0d_rst_y%0d", j, k), nodes_y_a[32*k +: 32], 32'h0);
        end
      end else begin
        chk($sformatf("vec%0d_x%0d", j, vecs[j].node), nodes_x_a[32*vecs[j].node +: 32], vecs[j].ex);
        chk($sformatf("vec%0d_y%0d", j, vecs[j].node), nodes_y_a[32*vecs[j].node +: 32], vecs[j].ey);
      end
    end

    // Random run of instance A against the model
    for (int k = 0; k < 400; k++) begin
      r = (k == 0) || ($urandom_range(0, 49) == 0);
      rst_a    = r;
      mx_a     = rnd_coord();
      my_a     = rnd_coord();
      prev_x_a = rnd_coord();
      prev_y_a = rnd_coord();
      next_x_a = rnd_coord();
      next_y_a = rnd_coord();
      if ($urandom_range(0, 7) == 0) last_a = $urandom_range(0, 1);
      model_step(r, mx_a, my_a, next_x_a, next_y_a, last_a);
      for (int i = 0; i < N; i++) begin
        e[32*i +: 32]     = mdl_x[i];
        e[W + 32*i +: 32] = mdl_y[i];
      end
      exp_q.push_back(e);
      tick();
      got = {nodes_y_a, nodes_x_a};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL rand%0d: got %h want %h", k, got, e);
      end
    end

    // Instance B: last node clamps to node3+8.0 and ignores next_core_first
    tick();
    chk("b_rst_x4", nodes_x_b[4*32 +: 32], 32'h0050_0000);
    rst_b = 1'b0;
    tick(); chk("b_e0_x0", nodes_x_b[0*32 +: 32], 32'h0008_0000);
    tick(); chk("b_e1_x1", nodes_x_b[1*32 +: 32], 32'h0010_0000);
    tick(); chk("b_e2_x2", nodes_x_b[2*32 +: 32], 32'h0018_0000);
    tick(); chk("b_e3_x3", nodes_x_b[3*32 +: 32], 32'h0020_0000);
    tick();
    chk("b_e4_x4", nodes_x_b[4*32 +: 32], 32'h0028_0000);
    chk("b_e4_y4", nodes_y_b[4*32 +: 32], 32'h0);
    tick(); chk("b_e5_x0", nodes_x_b[0*32 +: 32], 32'h0008_0000);

    // Instance C: negative predecessor exercises the arithmetic shift
    chk("c_rst_x1", nodes_x_c[32 +: 32], 32'h0);
    rst_c = 1'b0;
    tick(); tick(); tick();
    chk("c_e2_x0", nodes_x_c[0 +: 32], 32'hFFF8_0000);
    tick(); tick();
    chk("c_e4_x1", nodes_x_c[32 +: 32], 32'h0);
    tick();
    chk("c_e5_x1", nodes_x_c[32 +: 32], 32'hFFFE_0000);
    chk("c_e5_y1", nodes_y_c[32 +: 32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
